// File: rtl/mem_write_logger_if.sv
// Memory-bus snoop and log-drain signals for the write logger.
// The bus side is observed only; the log side is a valid/ready stream.
interface mem_write_logger_if;
  logic [25:0] ADDR;
  logic [31:0] DATA;
  logic        READ;
  logic        WRITE;
  logic        LOG_VALID;
  logic        LOG_READY;
  logic [25:0] LOG_ADDR;
  logic [31:0] LOG_DATA;

  modport master (
    output ADDR, DATA, READ, WRITE, LOG_READY,
    input  LOG_VALID, LOG_ADDR, LOG_DATA
  );

  modport slave (
    input  ADDR, DATA, READ, WRITE, LOG_READY,
    output LOG_VALID, LOG_ADDR, LOG_DATA
  );
endinterface

// File: rtl/mem_write_logger.sv
// Passive memory-write logger: captures rising-edge write strobes inside an
// address window into a show-ahead FIFO with drop counting and XOR signature.
module mem_write_logger #(
  parameter int          DEPTH     = 8,
  parameter logic [25:0] WIN_BASE  = 26'h0048000,
  parameter logic [25:0] WIN_LIMIT = 26'h0048011
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  mem_write_logger_if.slave        bus,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [7:0]               DROP_CNT,
  output logic [31:0]              CHECKSUM,
  output logic                     ERR
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [25:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      drop_q, drop_d;
  logic [31:0]     cks_q, cks_d;
  logic            err_q, err_d;
  logic            wr_q, wr_d;
  logic            log_valid_q, log_valid_d;
  logic [25:0]     log_addr_q, log_addr_d;
  logic [31:0]     log_data_q, log_data_d;

  logic            in_win, capture, full, pop, push, drop;
  entry_t          cap_entry;

  always_comb begin
    in_win    = (bus.ADDR >= WIN_BASE) && (bus.ADDR <= WIN_LIMIT);
    capture   = bus.WRITE & ~wr_q & ~bus.READ & ENABLE & in_win;
    full      = (count_q == DEPTH_C);
    pop       = log_valid_q & bus.LOG_READY;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    push      = capture & (~full | pop);
    drop      = capture & ~push;
    cap_entry = '{addr: bus.ADDR, data: bus.DATA};

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
    cks_d  = push ? (cks_q ^ {6'b0, bus.ADDR} ^ bus.DATA) : cks_q;
    err_d  = err_q | (bus.READ & bus.WRITE);
    wr_d   = bus.WRITE;

    // Output head is registered; bypass the array when the new head is the
    // entry being written on this very edge.
    log_valid_d = (count_d != '0);
    log_addr_d  = log_addr_q;
    log_data_d  = log_data_q;
    if (count_d != '0) begin
      if (push && count_d == CW'(1)) begin
        log_addr_d = cap_entry.addr;
        log_data_d = cap_entry.data;
      end else begin
        log_addr_d = mem_q[rptr_d].addr;
        log_data_d = mem_q[rptr_d].data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      cks_q       <= '0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      log_valid_q <= 1'b0;
      log_addr_q  <= '0;
      log_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      cks_q       <= cks_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      log_valid_q <= log_valid_d;
      log_addr_q  <= log_addr_d;
      log_data_q  <= log_data_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (!RST && push) mem_q[wptr_q] <= cap_entry;
  end

  assign bus.LOG_VALID = log_valid_q;
  assign bus.LOG_ADDR  = log_addr_q;
  assign bus.LOG_DATA  = log_data_q;
  assign COUNT         = count_q;
  assign FULL          = full;
  assign EMPTY         = (count_q == '0);
  assign DROP_CNT      = drop_q;
  assign CHECKSUM      = cks_q;
  assign ERR           = err_q;
endmodule

// File: tb/tb_mem_write_logger.sv
// Bench for mem_write_logger: reference queue model plus directed table and
// multi-cycle sequences (fill/drop, full push+pop, reset, saturation).
module tb_mem_write_logger;
  localparam int          DEPTH = 8;
  localparam logic [25:0] BASE  = 26'h0048000;
  localparam logic [25:0] LIMIT = 26'h0048011;

  logic        CLK = 1'b0;
  logic        RST, ENABLE;
  logic [3:0]  COUNT;
  logic        FULL, EMPTY, ERR;
  logic [7:0]  DROP_CNT;
  logic [31:0] CHECKSUM;

  mem_write_logger_if bus();

  mem_write_logger #(.DEPTH(DEPTH), .WIN_BASE(BASE), .WIN_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .bus(bus),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .DROP_CNT(DROP_CNT),
    .CHECKSUM(CHECKSUM), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [25:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  ent_t        m_head;
  logic [7:0]  m_drop;
  logic [31:0] m_cks;
  logic        m_err, m_wr;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input logic rst, input logic en, input logic [25:0] a,
                      input logic [31:0] d, input logic rd, input logic wr,
                      input logic rdy);
    ent_t e;
    logic cap;
    RST = rst; ENABLE = en;
    bus.ADDR = a; bus.DATA = d; bus.READ = rd; bus.WRITE = wr; bus.LOG_READY = rdy;
    if (rst) begin
      q.delete();
      m_drop = '0; m_cks = '0; m_err = 1'b0; m_wr = 1'b0; m_head = '0;
    end else begin
      if (q.size() != 0 && rdy) begin
        e = q.pop_front();
        check("pop_addr", {6'b0, bus.LOG_ADDR}, {6'b0, e.a});
        check("pop_data", bus.LOG_DATA, e.d);
      end
      cap = wr && !m_wr && !rd && en && (a >= BASE) && (a <= LIMIT);
      if (cap) begin
        if (q.size() < DEPTH) begin
          q.push_back('{a: a, d: d});
          m_cks = m_cks ^ {6'b0, a} ^ d;
        end else if (m_drop != 8'hFF) begin
          m_drop = m_drop + 8'd1;
        end
      end
      if (rd && wr) m_err = 1'b1;
      m_wr = wr;
      if (q.size() != 0) m_head = q[0];
    end
    @(posedge CLK); #1;
    check("count",    {28'b0, COUNT}, q.size());
    check("valid",    {31'b0, bus.LOG_VALID}, {31'b0, q.size() != 0});
    check("full",     {31'b0, FULL},  {31'b0, q.size() == DEPTH});
    check("empty",    {31'b0, EMPTY}, {31'b0, q.size() == 0});
    check("head_addr",{6'b0, bus.LOG_ADDR}, {6'b0, m_head.a});
    check("head_data",bus.LOG_DATA, m_head.d);
    check("drop_cnt", {24'b0, DROP_CNT}, {24'b0, m_drop});
    check("checksum", CHECKSUM, m_cks);
    check("err",      {31'b0, ERR}, {31'b0, m_err});
  endtask

  task automatic pulse(input logic [25:0] a, input logic [31:0] d, input logic rdy);
    step(1'b0, 1'b1, a, d, 1'b0, 1'b1, rdy);
    step(1'b0, 1'b1, a, d, 1'b0, 1'b0, rdy);
  endtask

  typedef struct {
    logic        en;
    logic [25:0] a;
    logic [31:0] d;
    logic        rd, wr, rdy;
    int          exp_count;
    logic [31:0] exp_cks;
    logic        exp_err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Hand-computed expectations: window edges, held strobe, pops, ERR.
    tbl[0]  = '{1'b1, 26'h0047FFF, 32'h000000AA, 1'b0, 1'b1, 1'b0, 0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 26'h0047FFF, 32'h000000AA, 1'b0, 1'b0, 1'b0, 0, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 26'h0048012, 32'h000000BB, 1'b0, 1'b1, 1'b0, 0, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 26'h0048012, 32'h000000BB, 1'b0, 1'b0, 1'b0, 0, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 26'h0048000, 32'h00000005, 1'b0, 1'b1, 1'b0, 1, 32'h00048005, 1'b0};
    tbl[5]  = '{1'b1, 26'h0048000, 32'h00000005, 1'b0, 1'b1, 1'b0, 1, 32'h00048005, 1'b0};
    tbl[6]  = '{1'b1, 26'h0048000, 32'h00000005, 1'b0, 1'b1, 1'b0, 1, 32'h00048005, 1'b0};
    tbl[7]  = '{1'b1, 26'h0048000, 32'h00000005, 1'b0, 1'b0, 1'b0, 1, 32'h00048005, 1'b0};
    tbl[8]  = '{1'b1, 26'h0048011, 32'h00000100, 1'b0, 1'b1, 1'b0, 2, 32'h00000114, 1'b0};
    tbl[9]  = '{1'b1, 26'h0048011, 32'h00000100, 1'b0, 1'b0, 1'b1, 1, 32'h00000114, 1'b0};
    tbl[10] = '{1'b1, 26'h0048011, 32'h00000100, 1'b0, 1'b0, 1'b1, 0, 32'h00000114, 1'b0};
    tbl[11] = '{1'b1, 26'h0048011, 32'h00000100, 1'b0, 1'b0, 1'b1, 0, 32'h00000114, 1'b0};
    tbl[12] = '{1'b1, 26'h0048001, 32'h00000007, 1'b1, 1'b1, 1'b0, 0, 32'h00000114, 1'b1};
    tbl[13] = '{1'b1, 26'h0048001, 32'h00000007, 1'b0, 1'b0, 1'b0, 0, 32'h00000114, 1'b1};
    tbl[14] = '{1'b0, 26'h0048002, 32'h00000009, 1'b0, 1'b1, 1'b0, 0, 32'h00000114, 1'b1};
    tbl[15] = '{1'b1, 26'h0048002, 32'h00000009, 1'b0, 1'b0, 1'b0, 0, 32'h00000114, 1'b1};

    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_log_addr", {6'b0, bus.LOG_ADDR}, 32'h0);
    check("rst_log_data", bus.LOG_DATA, 32'h0);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].en, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].rdy);
      check($sformatf("tbl%0d_count", i), {28'b0, COUNT}, tbl[i].exp_count);
      check($sformatf("tbl%0d_cks", i), CHECKSUM, tbl[i].exp_cks);
      check($sformatf("tbl%0d_err", i), {31'b0, ERR}, {31'b0, tbl[i].exp_err});
    end

    // Overfill: 10 captures into 8 slots.
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) pulse(BASE + 26'(i), 32'hA000 + 32'(i), 1'b0);
    check("ovf_count", {28'b0, COUNT}, 32'd8);
    check("ovf_full",  {31'b0, FULL}, 32'd1);
    check("ovf_drop",  {24'b0, DROP_CNT}, 32'd2);

    // Full FIFO with simultaneous pop and capture.
    step(1'b0, 1'b1, 26'h0048010, 32'hBEEF, 1'b0, 1'b1, 1'b1);
    check("fullpp_count", {28'b0, COUNT}, 32'd8);
    check("fullpp_drop",  {24'b0, DROP_CNT}, 32'd2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, BASE, '0, 1'b0, 1'b0, 1'b1);
    check("drain_empty", {31'b0, EMPTY}, 32'd1);
    check("drain_last",  bus.LOG_DATA, 32'hBEEF);

    // Reset mid-operation with COUNT=5, DROP_CNT=3, ERR set.
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) pulse(BASE + 26'(i), 32'h5000 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, BASE, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, BASE, '0, 1'b1, 1'b1, 1'b0);
    check("pre_rst_count", {28'b0, COUNT}, 32'd5);
    check("pre_rst_drop",  {24'b0, DROP_CNT}, 32'd3);
    check("pre_rst_err",   {31'b0, ERR}, 32'd1);
    step(1'b1, 1'b1, 26'h0048003, 32'h77, 1'b0, 1'b1, 1'b1);
    check("rst_count", {28'b0, COUNT}, 32'd0);
    check("rst_empty", {31'b0, EMPTY}, 32'd1);
    check("rst_valid", {31'b0, bus.LOG_VALID}, 32'd0);
    check("rst_laddr", {6'b0, bus.LOG_ADDR}, 32'h0);
    check("rst_ldata", bus.LOG_DATA, 32'h0);
    check("rst_drop",  {24'b0, DROP_CNT}, 32'd0);
    check("rst_cks",   CHECKSUM, 32'h0);
    check("rst_err",   {31'b0, ERR}, 32'd0);

    // WRITE held across reset release captures exactly once.
    step(1'b0, 1'b1, 26'h0048003, 32'h77, 1'b0, 1'b1, 1'b0);
    check("hold_count", {28'b0, COUNT}, 32'd1);
    check("hold_cks",   CHECKSUM, 32'h00048074);
    step(1'b0, 1'b1, 26'h0048003, 32'h77, 1'b0, 1'b1, 1'b0);
    check("hold_count2", {28'b0, COUNT}, 32'd1);

    // Drop counter saturation.
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 + 260; i++) pulse(BASE + 26'(i % 18), 32'(i), 1'b0);
    check("drop_sat", {24'b0, DROP_CNT}, 32'hFF);

    // Random traffic against the model.
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      step(1'b0, ($urandom_range(0, 9) != 0), BASE - 26'd2 + 26'($urandom_range(0, 21)),
           $urandom, ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 2) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
